// File: rtl/fibonacci_sequencer_pkg.sv
// Shared types and constants for the on-demand Fibonacci sequencer.
// Seed terms F(0)/F(1) live here so the datapath and any model agree on them.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ITER = 2'd1,
    RESP = 2'd2
  } fib_state_t;

  localparam int FIB_F0 = 0;
  localparam int FIB_F1 = 1;

endpackage

// File: rtl/fibonacci_sequencer_if.sv
// Request/response bundle between a requester (master) and the sequencer (slave).
interface fibonacci_sequencer_if #(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
);
  logic             req_valid;
  logic             req_ready;
  logic [IDX_W-1:0] req_n;
  logic             abort;
  logic             resp_valid;
  logic             resp_ready;
  logic [WIDTH-1:0] resp_value;
  logic             resp_overflow;
  logic             busy;

  modport master (
    output req_valid, req_n, abort, resp_ready,
    input  req_ready, resp_valid, resp_value, resp_overflow, busy
  );

  modport slave (
    input  req_valid, req_n, abort, resp_ready,
    output req_ready, resp_valid, resp_value, resp_overflow, busy
  );
endinterface

// File: rtl/fibonacci_sequencer_datapath.sv
// Two-term Fibonacci stepper: a holds F(k), b holds F(k+1), each with a sticky
// overflow flag that follows its term as it shifts from b into a.
module fib_step_datapath
  import fib_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic             i_step,
  output logic [WIDTH-1:0] o_a,
  output logic             o_a_ovf
);

  logic [WIDTH-1:0] r_a, r_b;
  logic             r_a_ovf, r_b_ovf;
  logic [WIDTH:0]   w_sum;

  assign w_sum = {1'b0, r_a} + {1'b0, r_b};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a     <= WIDTH'(FIB_F0);
      r_b     <= WIDTH'(FIB_F1);
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (i_load) begin
      r_a     <= WIDTH'(FIB_F0);
      r_b     <= WIDTH'(FIB_F1);
      r_a_ovf <= 1'b0;
      r_b_ovf <= 1'b0;
    end else if (i_step) begin
      r_a     <= r_b;
      r_b     <= w_sum[WIDTH-1:0];
      // new b overflowed if either addend already had, or this add carried out
      r_b_ovf <= r_b_ovf | w_sum[WIDTH] | r_a_ovf;
      r_a_ovf <= r_b_ovf;
    end
  end

  assign o_a     = r_a;
  assign o_a_ovf = r_a_ovf;

endmodule

// File: rtl/fibonacci_sequencer.sv
// Accepts an index n, steps the datapath n times, and returns F(n) with a
// sticky overflow flag through a valid/ready response port.
module fibonacci_sequencer
  import fib_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int IDX_W = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  fibonacci_sequencer_if.slave  io_fib
);

  fib_state_t       r_state;
  logic [IDX_W-1:0] r_cnt;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_value;
  logic             r_resp_ovf;

  logic             w_accept;
  logic             w_load;
  logic             w_step;
  logic [WIDTH-1:0] w_a;
  logic             w_a_ovf;

  assign w_accept = io_fib.req_valid && (r_state == IDLE) && !rst;
  assign w_load   = w_accept;
  assign w_step   = (r_state == ITER) && (r_cnt != '0) && !io_fib.abort;

  fib_step_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_load),
    .i_step  (w_step),
    .o_a     (w_a),
    .o_a_ovf (w_a_ovf)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_cnt        <= '0;
      r_resp_valid <= 1'b0;
      r_resp_value <= '0;
      r_resp_ovf   <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_cnt   <= io_fib.req_n;
            r_state <= ITER;
          end
        end
        ITER: begin
          if (io_fib.abort) begin
            r_state <= IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - 1'b1;
          end else begin
            r_resp_value <= w_a;
            r_resp_ovf   <= w_a_ovf;
            r_resp_valid <= 1'b1;
            r_state      <= RESP;
          end
        end
        RESP: begin
          // abort wins over a same-cycle handshake: the result is simply dropped
          if (io_fib.abort || io_fib.resp_ready) begin
            r_resp_valid <= 1'b0;
            r_state      <= IDLE;
          end
        end
        default: begin
          r_resp_valid <= 1'b0;
          r_state      <= IDLE;
        end
      endcase
    end
  end

  assign io_fib.req_ready     = (r_state == IDLE) && !rst;
  assign io_fib.resp_valid    = r_resp_valid;
  assign io_fib.resp_value    = r_resp_value;
  assign io_fib.resp_overflow = r_resp_ovf;
  assign io_fib.busy          = (r_state != IDLE);

endmodule

// File: tb/tb_fibonacci_sequencer.sv
// Directed bench: stimulus pushes hand-computed F(n) into a queue, a monitor
// pops and compares on every response handshake.
module tb_fibonacci_sequencer;
  localparam int W  = 32;
  localparam int IW = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fibonacci_sequencer_if #(.WIDTH(W), .IDX_W(IW)) bus ();

  fibonacci_sequencer #(.WIDTH(W), .IDX_W(IW)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_fib (bus)
  );

  typedef struct {
    logic [W-1:0] v;
    logic         o;
  } exp_t;

  exp_t q[$];
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: one comparison set per completed handshake
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.resp_valid && bus.resp_ready && !bus.abort) begin
        if (q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got value %0d with no request pending", bus.resp_value);
        end else begin
          e = q.pop_front();
          chk("resp_value", bus.resp_value, e.v);
          chk("resp_overflow", bus.resp_overflow, e.o);
        end
      end
    end
  end

  task automatic wait_ready();
    int k = 0;
    while (!bus.req_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    if (!bus.req_ready) chk("req_ready_timeout", 0, 1);
  endtask

  task automatic accept(input int n);
    wait_ready();
    bus.req_valid = 1'b1;
    bus.req_n     = IW'(n);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_n     = '1;
  endtask

  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!bus.resp_valid && lat < 200);
  endtask

  task automatic wait_drop();
    int k = 0;
    while (bus.resp_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    if (bus.resp_valid) chk("resp_drop_timeout", 1, 0);
  endtask

  task automatic run(input int n, input logic [W-1:0] ev, input logic eo);
    int lat;
    accept(n);
    q.push_back('{v: ev, o: eo});
    wait_valid(lat);
    chk($sformatf("latency_n%0d", n), lat, n + 1);
    wait_drop();
  endtask

  initial begin
    int lat;
    int seen;
    bus.req_valid  = 1'b0;
    bus.req_n      = '0;
    bus.abort      = 1'b0;
    bus.resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 0);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_resp_value", bus.resp_value, 0);
    chk("rst_resp_ovf", bus.resp_overflow, 0);
    chk("rst_busy", bus.busy, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("idle_req_ready", bus.req_ready, 1);

    run(0, 32'd0, 1'b0);
    run(1, 32'd1, 1'b0);
    run(2, 32'd1, 1'b0);
    run(10, 32'd55, 1'b0);
    run(20, 32'd6765, 1'b0);
    run(47, 32'd2971215073, 1'b0);
    run(48, 32'd512559680, 1'b1);
    run(50, 32'd3996334433, 1'b1);

    // backpressure: result held, second request ignored
    bus.resp_ready = 1'b0;
    accept(5);
    q.push_back('{v: 32'd5, o: 1'b0});
    wait_valid(lat);
    chk("bp_latency", lat, 6);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid_held", bus.resp_valid, 1);
      chk("bp_value_stable", bus.resp_value, 5);
      chk("bp_req_ready_low", bus.req_ready, 0);
      bus.req_valid = 1'b1;
      bus.req_n     = IW'(3);
      @(posedge clk); #1;
    end
    bus.req_valid  = 1'b0;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_valid_dropped", bus.resp_valid, 0);
    chk("bp_req_ready_back", bus.req_ready, 1);

    // abort mid-ITER
    accept(30);
    repeat (9) begin @(posedge clk); #1; end
    bus.abort = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("abort_busy", bus.busy, 0);
    chk("abort_req_ready", bus.req_ready, 1);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (bus.resp_valid) seen++;
    end
    chk("abort_no_resp", seen, 0);
    run(5, 32'd5, 1'b0);

    // abort in RESP beats a same-cycle handshake
    bus.resp_ready = 1'b0;
    accept(3);
    wait_valid(lat);
    chk("resp_abort_valid_up", bus.resp_valid, 1);
    bus.abort      = 1'b1;
    bus.resp_ready = 1'b1;
    @(posedge clk); #1;
    bus.abort = 1'b0;
    chk("resp_abort_dropped", bus.resp_valid, 0);
    chk("resp_abort_idle", bus.busy, 0);

    // asynchronous reset mid-ITER, off the clock edge
    accept(30);
    repeat (8) begin @(posedge clk); #1; end
    #3;
    rst = 1'b1;
    #1;
    chk("arst_busy", bus.busy, 0);
    chk("arst_resp_valid", bus.resp_valid, 0);
    chk("arst_resp_value", bus.resp_value, 0);
    chk("arst_req_ready", bus.req_ready, 0);
    #2;
    rst = 1'b0;
    @(posedge clk); #1;
    run(6, 32'd8, 1'b0);

    repeat (3) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
